apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
//  Parametrised APB3 completer: register-array memory of DEPTH words, DWIDTH bits each, word-addressed.
//  Adds programmable wait states and a p_slverr error response on out-of-range addresses.
//  Sits behind the APB requester/interface in the APB testbench and subsystem tops.
// PARAMETERS
//  AWIDTH       8    address width; addr is a word index
//  DWIDTH       32   data width; must be a multiple of 8
//  DEPTH        256  number of words; legal range 1..2**AWIDTH
//  WAIT_CYCLES  0    access-phase wait states inserted before p_ready; legal range 0..15
// PORTS
//  clk       in   1       clock; all logic on the rising edge
//  rst       in   1       reset, synchronous, active-high
//  p_sel     in   1       select
//  p_en      in   1       enable (access phase)
//  p_write   in   1       1 = write, 0 = read
//  addr      in   AWIDTH  word address
//  wdata     in   DWIDTH  write data
//  p_strb    in   DWIDTH/8  byte write strobes (present only with APB_STRB_EN)
//  rdata     out  DWIDTH  read data, registered
//  p_ready   out  1       transfer completes on the edge where p_sel & p_en & p_ready
//  p_slverr  out  1       error; valid only while p_ready=1
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, wait_cnt=0, rdata=0, every mem word=0.
//  Reset outputs: p_ready=0, p_slverr=0.
//  FSM states: IDLE, ACCESS.
//   IDLE: if p_sel & !p_en (setup) -> ACCESS, wait_cnt<=0, latch addr, p_write, oor=(addr>=DEPTH).
//   IDLE: setup phase with a read: rdata <= oor ? 0 : mem[addr].
//   ACCESS: p_ready = (wait_cnt==WAIT_CYCLES), combinational from registered state.
//   ACCESS: p_slverr = p_ready & oor.
//   ACCESS: while !p_ready and p_sel & p_en: wait_cnt++.
//   ACCESS: on an edge with p_sel & p_en & p_ready: commit, then -> IDLE.
//   Commit: write and !oor -> mem[latched addr] <= wdata; oor write -> memory unchanged.
//   ACCESS: p_sel=0 at any edge -> abort: no write, -> IDLE; p_ready and p_slverr are 0 next cycle.
//  Latency: WAIT_CYCLES=0 gives a 2-cycle transfer (setup + access); each wait state adds 1 cycle.
//  Back-to-back: IDLE accepts a new setup on the cycle immediately after completion, with no idle gap.
//  addr/p_write/wdata may change during ACCESS; addr and p_write use the latched values.
//  wdata is sampled at the completion edge.
//  Read data: stays stable from the access phase until the next read setup.
//  Read data: a write never changes rdata; read-after-write to the same address returns the new data.
//  p_en=1 while in IDLE (protocol violation): ignored; stays in IDLE.
//  rst asserted mid-transfer: transfer is dropped, memory is cleared, p_ready=0 from the next cycle.
//  Outputs never take X after the first reset edge.
// CONFIGURATION
//  APB_STRB_EN defined: p_strb port exists; write updates only byte lanes i where p_strb[i]=1.
//   p_strb=0 on a write completes with p_ready and no memory change.
//   Reads ignore p_strb.
//  APB_STRB_EN undefined: no p_strb port; every write updates the full word.
// TESTING
//  Reset, then read addr 0x05 -> rdata=0, p_slverr=0, p_ready in the 2nd cycle of the transfer.
//  Write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> rdata=0xDEADBEEF; each transfer takes 2 cycles.
//  WAIT_CYCLES=3: write then read 0x20 -> p_ready low for 3 access cycles, high on the 4th.
//  DEPTH=16: write 0xA5A5A5A5 to 0x20 -> p_slverr=1 with p_ready.
//   Read 0x20 -> rdata=0, p_slverr=1.
//   Read 0x00..0x0F -> all unchanged.
//  Drop p_sel in a WAIT_CYCLES=2 write to 0x04 -> no write, then read 0x04 -> 0.
//   Assert rst mid-transfer -> all memory reads 0.
//  APB_STRB_EN: write 0xFFFFFFFF to 0x03, then 0x12345678 with p_strb=4'b0101 -> read 0xFF34FF78.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a DEPTH x DWIDTH register array, with WAIT_CYCLES access wait states
// and p_slverr on out-of-range words. Define APB_STRB_EN to add the p_strb byte-lane write port.
module apb_slave_mem #(
  parameter int AWIDTH      = 8,
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_sel,
  input  logic              p_en,
  input  logic              p_write,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
`ifdef APB_STRB_EN
  input  logic [DWIDTH/8-1:0] p_strb,
`endif
  output logic [DWIDTH-1:0] rdata,
  output logic              p_ready,
  output logic              p_slverr
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               write_q, write_d;
  logic               oor_q, oor_d;
  logic [DWIDTH-1:0]  rdata_q, rdata_d;
  logic [DWIDTH-1:0]  mem_q [DEPTH];

  logic               addr_oor;
  logic               commit;
  logic [DWIDTH-1:0]  wmask;

  function automatic logic is_oor(input logic [AWIDTH-1:0] a);
    return 32'(a) >= 32'(DEPTH);
  endfunction

  assign addr_oor = is_oor(addr);
  assign rdata    = rdata_q;

`ifdef APB_STRB_EN
  always_comb begin
    wmask = '0;
    for (int i = 0; i < DWIDTH/8; i++) wmask[i*8 +: 8] = {8{p_strb[i]}};
  end
`else
  assign wmask = '1;
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    oor_d      = oor_q;
    rdata_d    = rdata_q;
    commit     = 1'b0;
    p_ready    = 1'b0;
    p_slverr   = 1'b0;
    case (state_q)
      IDLE: begin
        // p_en without a preceding setup phase is a protocol violation and is ignored
        if (p_sel && !p_en) begin
          state_d    = ACCESS;
          wait_cnt_d = '0;
          idx_d      = addr[IDX_W-1:0];
          write_d    = p_write;
          oor_d      = addr_oor;
          if (!p_write) rdata_d = addr_oor ? '0 : mem_q[addr[IDX_W-1:0]];
        end
      end
      ACCESS: begin
        p_ready  = (wait_cnt_q == WAIT_C);
        p_slverr = p_ready && oor_q;
        if (!p_sel) begin
          state_d = IDLE;
        end else if (p_en) begin
          if (p_ready) begin
            commit  = write_q && !oor_q;
            state_d = IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      oor_q      <= 1'b0;
      rdata_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      oor_q      <= oor_d;
      rdata_q    <= rdata_d;
      // wdata is taken live at the completion edge; address comes from the setup latch
      if (commit) mem_q[idx_q] <= (mem_q[idx_q] & ~wmask) | (wdata & wmask);
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances (WAIT 0/DEPTH 256, WAIT 3/DEPTH 256,
// WAIT 2/DEPTH 16); the driver queues expected completions, a negedge monitor checks them.
module tb_apb_slave_mem;

  localparam int WAITS [3] = '{0, 3, 2};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  logic        clk;
  logic [2:0]  rst, sel, en, wr;
  logic [7:0]  ad [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];
  logic [3:0]  sb [3];
  logic [2:0]  rdy, err;

  exp_t sbq [3][$];
  int   waits [3];
  int   total = 0;
  int   bad   = 0;

  apb_slave_mem #(.AWIDTH(8), .DWIDTH(32), .DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]), .p_sel(sel[0]), .p_en(en[0]), .p_write(wr[0]),
    .addr(ad[0]), .wdata(wd[0]),
`ifdef APB_STRB_EN
    .p_strb(sb[0]),
`endif
    .rdata(rd[0]), .p_ready(rdy[0]), .p_slverr(err[0]));

  apb_slave_mem #(.AWIDTH(8), .DWIDTH(32), .DEPTH(256), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst[1]), .p_sel(sel[1]), .p_en(en[1]), .p_write(wr[1]),
    .addr(ad[1]), .wdata(wd[1]),
`ifdef APB_STRB_EN
    .p_strb(sb[1]),
`endif
    .rdata(rd[1]), .p_ready(rdy[1]), .p_slverr(err[1]));

  apb_slave_mem #(.AWIDTH(8), .DWIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst[2]), .p_sel(sel[2]), .p_en(en[2]), .p_write(wr[2]),
    .addr(ad[2]), .wdata(wd[2]),
`ifdef APB_STRB_EN
    .p_strb(sb[2]),
`endif
    .rdata(rd[2]), .p_ready(rdy[2]), .p_slverr(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h", nm, k, act, req);
    end
  endtask

  // Monitor: pops one expectation per completed transfer and checks data, error and wait count
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst[k] || !sel[k]) begin
        waits[k] = 0;
      end else if (en[k] && !rdy[k]) begin
        waits[k]++;
      end else if (en[k] && rdy[k]) begin
        if (sbq[k].size() == 0) begin
          chk("unexpected_completion", k, 32'd1, 32'd0);
        end else begin
          e = sbq[k].pop_front();
          chk("rdata", k, rd[k], e.rdata);
          chk("slverr", k, {31'd0, err[k]}, {31'd0, e.err});
          chk("wait_states", k, 32'(waits[k]), 32'(e.waits));
        end
        waits[k] = 0;
      end
    end
  end

  // Starts just after a rising edge; returns just after the completion edge with sel still high
  task automatic xfer(input int k, input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit exp_err);
    int n;
    sbq[k].push_back('{exp_rd, exp_err, WAITS[k]});
    sel[k] = 1'b1; en[k] = 1'b0; wr[k] = w; ad[k] = a; wd[k] = d;
    @(posedge clk); #1;
    en[k] = 1'b1;
    ad[k] = a ^ 8'hFF;
    wr[k] = !w;
    n = 0;
    @(negedge clk);
    while (!rdy[k] && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (!rdy[k]) begin
      chk("ready_timeout", k, 32'd0, 32'd1);
      void'(sbq[k].pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    sel[k] = 1'b0; en[k] = 1'b0; wr[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 3'b111; sel = '0; en = '0; wr = '0;
    for (int k = 0; k < 3; k++) begin
      ad[k] = '0; wd[k] = '0; sb[k] = 4'hF; waits[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_rdata", k, rd[k], 32'd0);
      chk("reset_ready", k, {31'd0, rdy[k]}, 32'd0);
      chk("reset_slverr", k, {31'd0, err[k]}, 32'd0);
    end
    @(posedge clk); #1;

    // dut0: p_en asserted from IDLE is ignored
    sel[0] = 1'b1; en[0] = 1'b1; wr[0] = 1'b1; ad[0] = 8'h05; wd[0] = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("idle_pen_ready", 0, {31'd0, rdy[0]}, 32'd0);
    end
    @(posedge clk); #1;
    idle(0);

    // dut0: two-cycle transfers, back-to-back, rdata held across writes
    xfer(0, 1'b0, 8'h05, 32'h0, 32'h0, 1'b0);
    xfer(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer(0, 1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b1, 8'h11, 32'h0123_4567, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, 8'h11, 32'h0, 32'h0123_4567, 1'b0);
`ifdef APB_STRB_EN
    sb[0] = 4'hF;
    xfer(0, 1'b1, 8'h03, 32'hFFFF_FFFF, 32'h0123_4567, 1'b0);
    sb[0] = 4'b0101;
    xfer(0, 1'b1, 8'h03, 32'h1234_5678, 32'h0123_4567, 1'b0);
    sb[0] = 4'b0000;
    xfer(0, 1'b1, 8'h03, 32'h0000_0000, 32'h0123_4567, 1'b0);
    sb[0] = 4'b0000;
    xfer(0, 1'b0, 8'h03, 32'h0, 32'hFF34_FF78, 1'b0);
    sb[0] = 4'hF;
`endif
    idle(0);

    // dut1: three wait states
    xfer(1, 1'b1, 8'h20, 32'h0BAD_F00D, 32'h0, 1'b0);
    xfer(1, 1'b0, 8'h20, 32'h0, 32'h0BAD_F00D, 1'b0);
    idle(1);

    // dut2: out-of-range accesses must not alias onto in-range words
    xfer(2, 1'b1, 8'h00, 32'h0000_0001, 32'h0, 1'b0);
    xfer(2, 1'b1, 8'h0F, 32'h0000_F00F, 32'h0, 1'b0);
    xfer(2, 1'b1, 8'h20, 32'hA5A5_A5A5, 32'h0, 1'b1);
    xfer(2, 1'b0, 8'h20, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++)
      xfer(2, 1'b0, 8'(i), 32'h0, (i == 0) ? 32'h1 : (i == 15) ? 32'hF00F : 32'h0, 1'b0);
    idle(2);

    // dut2: drop p_sel while p_ready is already high
    sel[2] = 1'b1; en[2] = 1'b0; wr[2] = 1'b1; ad[2] = 8'h04; wd[2] = 32'h4444_4444;
    @(posedge clk); #1;
    en[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1 sel[2] = 1'b0; en[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", 2, {31'd0, rdy[2]}, 32'd0);
    chk("abort_slverr", 2, {31'd0, err[2]}, 32'd0);
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'h04, 32'h0, 32'h0, 1'b0);
    xfer(2, 1'b1, 8'h07, 32'h0000_0077, 32'h0, 1'b0);
    idle(2);

    // dut2: reset in the middle of a transfer clears memory
    sel[2] = 1'b1; en[2] = 1'b0; wr[2] = 1'b1; ad[2] = 8'h07; wd[2] = 32'h0000_0099;
    @(posedge clk); #1;
    en[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0; sel[2] = 1'b0; en[2] = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 2, {31'd0, rdy[2]}, 32'd0);
    chk("midrst_rdata", 2, rd[2], 32'd0);
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'h07, 32'h0, 32'h0, 1'b0);
    xfer(2, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);
    idle(2);

    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) chk("scoreboard_left", k, 32'(sbq[k].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
